// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, ExcCodes, exc_vec bit positions,
// the BEV exception entry and the exception priority resolver.
package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam int EV_INT     = 0;
    localparam int EV_ADEL_IF = 1;
    localparam int EV_RI      = 2;
    localparam int EV_OV      = 3;
    localparam int EV_SYS     = 4;
    localparam int EV_BP      = 5;
    localparam int EV_ADEL_LS = 6;
    localparam int EV_ADES    = 7;

    localparam logic [31:0] BEV_ENTRY = 32'hBFC0_0380;

    typedef struct packed {
        logic [4:0] code;
        logic       bva;   // cause captures BadVAddr
    } exc_sel_t;

    // Lowest set bit of exc_vec wins.
    function automatic exc_sel_t exc_resolve(input logic [7:0] vec);
        exc_sel_t r;
        int       idx;
        idx = 0;
        for (int i = 7; i >= 0; i--)
            if (vec[i]) idx = i;
        case (idx)
            EV_ADEL_IF: r.code = EXC_ADEL;
            EV_RI:      r.code = EXC_RI;
            EV_OV:      r.code = EXC_OV;
            EV_SYS:     r.code = EXC_SYS;
            EV_BP:      r.code = EXC_BP;
            EV_ADEL_LS: r.code = EXC_ADEL;
            EV_ADES:    r.code = EXC_ADES;
            default:    r.code = EXC_INT;
        endcase
        r.bva = (idx == EV_ADEL_IF) || (idx == EV_ADEL_LS) || (idx == EV_ADES);
        return r;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Prescaled Count, Compare and the sticky timer-interrupt flag TI.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d, compare_q, compare_d;
    logic          ti_q, ti_d;
    logic          tick;

    always_comb begin
        tick      = (presc_q == PW'(COUNT_DIV - 1));
        presc_d   = (tick || count_wen) ? '0 : presc_q + 1'b1;
        count_d   = count_wen ? wdata : (tick ? count_q + 32'd1 : count_q);
        compare_d = compare_wen ? wdata : compare_q;
        ti_d      = ti_q;
        // A load counts as an advance, so loading Count==Compare fires TI.
        if (compare_wen)
            ti_d = 1'b0;
        else if ((count_wen || tick) && (count_d == compare_q))
            ti_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
endmodule

// File: rtl/cp0_unit.sv
// CP0 register file and exception/interrupt controller beside the WB stage.
module cp0_unit
    import cp0_defs::*;
#(
    parameter int          HW_INT_NUM  = 6,
    parameter int          COUNT_DIV   = 2,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_ENTRY   = BEV_ENTRY
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cp0_wen,
    input  logic [7:0]            cp0_addr,
    input  logic [31:0]           cp0_wdata,
    output logic [31:0]           cp0_rdata,
    input  logic [7:0]            exc_vec,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] ext_int,
    output logic                  int_pending,
    output logic                  exc_taken,
    output logic [31:0]           exc_target,
    output logic [31:0]           cp0_epc,
    output logic                  status_exl
);
    logic                  wr;
    logic [4:0]            wr_reg;
    exc_sel_t              sel;
    logic [31:0]           count, compare;
    logic                  ti;
    logic [HW_INT_NUM-1:0] ext_sync;
    logic [5:0]            ext6;

    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [7:0]  im_q, im_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [31:0] epc_q, epc_d, bva_q, bva_d;
    logic [7:0]  ip;
    logic [31:0] status, cause;

    assign wr        = cp0_wen && (cp0_addr[2:0] == 3'd0);
    assign wr_reg    = cp0_addr[7:3];
    assign exc_taken = resetn && (|exc_vec);
    assign sel       = exc_resolve(exc_vec);
    assign ext6      = 6'(ext_sync);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ext_sync = ext_int;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= ext_int;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end
            assign ext_sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk         (clk),
        .resetn      (resetn),
        .count_wen   (wr && (wr_reg == CP0_COUNT)),
        .compare_wen (wr && (wr_reg == CP0_COMPARE)),
        .wdata       (cp0_wdata),
        .count       (count),
        .compare     (compare),
        .ti          (ti)
    );

    always_comb begin
        exl_d      = exl_q;
        ie_d       = ie_q;
        im_d       = im_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        bva_d      = bva_q;
        ip_hw_d    = {ti | ext6[5], ext6[4:0]};
        if (wr && (wr_reg == CP0_STATUS)) begin
            im_d  = cp0_wdata[15:8];
            exl_d = cp0_wdata[1];
            ie_d  = cp0_wdata[0];
        end
        // Exception overrides ERET and any same-cycle MTC0 to EXL/Cause/EPC.
        if (exc_taken) begin
            exl_d      = 1'b1;
            exc_code_d = sel.code;
            if (!exl_q) begin
                epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_bd;
            end
            if (sel.bva) bva_d = exc_badvaddr;
        end else begin
            if (eret) exl_d = 1'b0;
            if (wr && (wr_reg == CP0_CAUSE)) ip_sw_d = cp0_wdata[9:8];
            if (wr && (wr_reg == CP0_EPC))   epc_d   = cp0_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            im_q       <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            ip_hw_q    <= '0;
            epc_q      <= '0;
            bva_q      <= '0;
        end else begin
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            im_q       <= im_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            epc_q      <= epc_d;
            bva_q      <= bva_d;
        end
    end

    assign ip     = {ip_hw_q, ip_sw_q};
    assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause  = {bd_q, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

    always_comb begin
        cp0_rdata = '0;
        if (cp0_addr[2:0] == 3'd0) begin
            case (cp0_addr[7:3])
                CP0_BADVADDR: cp0_rdata = bva_q;
                CP0_COUNT:    cp0_rdata = count;
                CP0_COMPARE:  cp0_rdata = compare;
                CP0_STATUS:   cp0_rdata = status;
                CP0_CAUSE:    cp0_rdata = cause;
                CP0_EPC:      cp0_rdata = epc_q;
                default:      cp0_rdata = '0;
            endcase
        end
    end

    assign int_pending = ie_q && !exl_q && (|(im_q & ip));
    assign exc_target  = exc_taken ? EXC_ENTRY : epc_q;
    assign cp0_epc     = epc_q;
    assign status_exl  = exl_q;
endmodule

// File: tb/tb_cp0_unit.sv
// Random + directed bench for cp0_unit against a behavioural register model.
module tb_cp0_unit;
    import cp0_defs::*;

    localparam int          HW  = 6;
    localparam int          DIV = 2;
    localparam int          SS  = 2;
    localparam logic [31:0] ENTRY = 32'hBFC0_0380;

    logic          clk = 1'b0, resetn = 1'b0;
    logic          cp0_wen = 1'b0, exc_bd = 1'b0, eret = 1'b0;
    logic [7:0]    cp0_addr = '0, exc_vec = '0;
    logic [31:0]   cp0_wdata = '0, exc_pc = '0, exc_badvaddr = '0;
    logic [HW-1:0] ext_int = '0;
    logic [31:0]   cp0_rdata, exc_target, cp0_epc;
    logic          int_pending, exc_taken, status_exl;

    cp0_unit #(.HW_INT_NUM(HW), .COUNT_DIV(DIV), .SYNC_STAGES(SS), .EXC_ENTRY(ENTRY)) dut (
        .clk(clk), .resetn(resetn), .cp0_wen(cp0_wen), .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata), .exc_vec(exc_vec), .exc_pc(exc_pc),
        .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret), .ext_int(ext_int),
        .int_pending(int_pending), .exc_taken(exc_taken), .exc_target(exc_target),
        .cp0_epc(cp0_epc), .status_exl(status_exl)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: Count is derived from elapsed edges since the last load.
    int          edge_n = 0, m_load_edge = 0;
    logic [31:0] m_cnt_base, m_cmp, m_epc, m_bva;
    logic        m_ti, m_exl, m_ie, m_bd;
    logic [7:0]  m_im;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_iphw;
    logic [5:0]  hist[$];
    logic [4:0]  codes [8] = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};

    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'((edge_n - m_load_edge) / DIV);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        if (a[2:0] != 3'd0) return 32'd0;
        case (a[7:3])
            5'd8:  return m_bva;
            5'd9:  return m_count();
            5'd11: return m_cmp;
            5'd12: return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13: return {m_bd, m_ti, 14'b0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b0};
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_pend();
        return m_ie && !m_exl && (|(m_im & {m_iphw, m_ipsw}));
    endfunction

    task automatic m_reset();
        m_cnt_base = 0; m_load_edge = edge_n; m_cmp = 0; m_epc = 0; m_bva = 0;
        m_ti = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_exc = 0; m_ipsw = 0; m_iphw = 0;
        hist.delete();
        repeat (SS) hist.push_back(6'd0);
    endtask

    task automatic m_edge();
        logic [31:0] old_cnt, new_cnt;
        logic        wr, ld, ti_before, old_exl;
        logic [4:0]  r;
        logic [5:0]  e;
        int          idx;
        old_cnt = m_count();
        edge_n++;
        wr = cp0_wen && (cp0_addr[2:0] == 3'd0);
        r  = cp0_addr[7:3];
        ld = wr && (r == 5'd9);
        if (ld) begin m_cnt_base = cp0_wdata; m_load_edge = edge_n; end
        new_cnt = m_count();
        ti_before = m_ti;
        if (wr && r == 5'd11) m_ti = 0;
        else if ((ld || new_cnt != old_cnt) && new_cnt == m_cmp) m_ti = 1;
        if (wr && r == 5'd11) m_cmp = cp0_wdata;
        hist.push_back(6'(ext_int));
        e = hist.pop_front();
        m_iphw = {ti_before | e[5], e[4:0]};
        old_exl = m_exl;
        if (wr && r == 5'd12) begin m_im = cp0_wdata[15:8]; m_ie = cp0_wdata[0]; end
        if (exc_vec != 0) begin
            idx = 0;
            while (!exc_vec[idx]) idx++;
            m_exc = codes[idx];
            if (!old_exl) begin m_epc = exc_bd ? exc_pc - 4 : exc_pc; m_bd = exc_bd; end
            if (idx == 1 || idx == 6 || idx == 7) m_bva = exc_badvaddr;
            m_exl = 1;
        end else begin
            if (wr && r == 5'd12) m_exl = cp0_wdata[1];
            if (wr && r == 5'd13) m_ipsw = cp0_wdata[9:8];
            if (wr && r == 5'd14) m_epc = cp0_wdata;
            if (eret) m_exl = 0;
        end
    endtask

    // One clock: check combinational outputs, take the edge, check state.
    task automatic cycle();
        #1;
        chk("rdata", cp0_rdata, m_read(cp0_addr));
        chk("int_pending", 32'(int_pending), 32'(m_pend()));
        chk("exc_taken", 32'(exc_taken), 32'(exc_vec != 0));
        chk("exc_target", exc_target, (exc_vec != 0) ? ENTRY : m_epc);
        @(posedge clk);
        m_edge();
        #1;
        chk("epc", cp0_epc, m_epc);
        chk("exl", 32'(status_exl), 32'(m_exl));
        @(negedge clk);
    endtask

    task automatic clear_in();
        cp0_wen = 0; exc_vec = 0; eret = 0; exc_bd = 0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        clear_in();
        cp0_wen = 1; cp0_addr = {r, 3'b0}; cp0_wdata = d;
        cycle();
        cp0_wen = 0;
    endtask

    task automatic rd_at(input logic [4:0] r);
        cp0_addr = {r, 3'b0};
        #1;
    endtask

    logic [4:0] regs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd20};

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        resetn = 1;
        m_reset();
        rd_at(CP0_STATUS); chk("rst_status", cp0_rdata, 32'h0040_0000);
        rd_at(CP0_COUNT);  chk("rst_count", cp0_rdata, 32'h0);
        rd_at(CP0_CAUSE);  chk("rst_cause", cp0_rdata, 32'h0);
        chk("rst_epc", cp0_epc, 32'h0);
        chk("rst_pend", 32'(int_pending), 32'h0);

        // Count wrap and timer
        mtc0(CP0_COUNT, 32'hFFFF_FFFE);
        mtc0(CP0_COMPARE, 32'h1);
        clear_in();
        repeat (3) cycle();
        rd_at(CP0_COUNT); chk("t1_wrap0", cp0_rdata, 32'h0);
        cycle();
        rd_at(CP0_CAUSE); chk("t1_ti_pre", 32'(cp0_rdata[30]), 32'h0);
        cycle();
        rd_at(CP0_COUNT); chk("t1_cnt1", cp0_rdata, 32'h1);
        rd_at(CP0_CAUSE); chk("t1_ti_set", 32'(cp0_rdata[30]), 32'h1);
        mtc0(CP0_COMPARE, 32'h40);
        rd_at(CP0_CAUSE); chk("t1_ti_clr", 32'(cp0_rdata[30]), 32'h0);

        // adel_if + ri in delay slot
        clear_in();
        exc_vec = 8'b0000_0110; exc_pc = 32'h8000_1000; exc_bd = 1; exc_badvaddr = 32'hDEAD_BEE0;
        cycle();
        clear_in();
        rd_at(CP0_CAUSE);    chk("t2_code", 32'(cp0_rdata[6:2]), 32'h04);
                             chk("t2_bd", 32'(cp0_rdata[31]), 32'h1);
        rd_at(CP0_BADVADDR); chk("t2_bva", cp0_rdata, 32'hDEAD_BEE0);
        chk("t2_epc", cp0_epc, 32'h8000_0FFC);
        chk("t2_exl", 32'(status_exl), 32'h1);

        // nested sys with EXL set
        exc_vec = 8'b0001_0000; exc_pc = 32'h8000_2000; exc_badvaddr = 32'h1234_5678;
        cycle();
        clear_in();
        chk("t3_epc", cp0_epc, 32'h8000_0FFC);
        rd_at(CP0_CAUSE);    chk("t3_code", 32'(cp0_rdata[6:2]), 32'h08);
        rd_at(CP0_BADVADDR); chk("t3_bva", cp0_rdata, 32'hDEAD_BEE0);
        eret = 1; cycle(); clear_in();

        // IRQ latency through synchronisers
        mtc0(CP0_STATUS, 32'h0000_0401);
        ext_int = 6'b000001;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            #1 chk($sformatf("t4_lat%0d", k), 32'(int_pending), 32'(k == 3));
        end
        mtc0(CP0_STATUS, 32'h0000_0403);
        chk("t4_exl_mask", 32'(int_pending), 32'h0);
        ext_int = '0;
        mtc0(CP0_STATUS, 32'h0);

        // exception beats MTC0 EPC; exception beats ERET
        clear_in();
        cp0_wen = 1; cp0_addr = {CP0_EPC, 3'b0}; cp0_wdata = 32'h1234;
        exc_vec = 8'b0000_1000; exc_pc = 32'h8000_3000;
        cycle();
        clear_in();
        chk("t5_epc", cp0_epc, 32'h8000_3000);
        rd_at(CP0_CAUSE); chk("t5_code", 32'(cp0_rdata[6:2]), 32'h0C);
        eret = 1; exc_vec = 8'b0001_0000;
        cycle();
        clear_in();
        chk("t5_eret_exc", 32'(status_exl), 32'h1);
        eret = 1; cycle(); clear_in();
        chk("t5_eret", 32'(status_exl), 32'h0);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] r;
            clear_in();
            r = regs[$urandom_range(0, 7)];
            cp0_addr = {r, ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b0};
            cp0_wen = ($urandom_range(0, 3) == 0);
            if (r == CP0_COUNT)
                cp0_wdata = $urandom_range(0, 1) ? m_cmp - 32'($urandom_range(0, 3)) : $urandom;
            else if (r == CP0_COMPARE)
                cp0_wdata = m_count() + 32'($urandom_range(0, 6));
            else
                cp0_wdata = $urandom;
            if ($urandom_range(0, 7) == 0)
                exc_vec = $urandom_range(0, 1) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom_range(1, 255));
            exc_pc = $urandom; exc_badvaddr = $urandom; exc_bd = 1'($urandom);
            eret = ($urandom_range(0, 9) == 0) && !(cp0_wen && r == CP0_STATUS);
            if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
            cycle();
        end

        // asynchronous reset with TI and EXL set
        clear_in(); ext_int = '0;
        mtc0(CP0_COMPARE, 32'h101);
        mtc0(CP0_COUNT, 32'h101);
        exc_vec = 8'b0000_0001; exc_pc = 32'h8000_4000; cycle(); clear_in();
        rd_at(CP0_CAUSE); chk("t6_ti_pre", 32'(cp0_rdata[30]), 32'h1);
        chk("t6_exl_pre", 32'(status_exl), 32'h1);
        exc_vec = 8'b0000_1000;
        #1 resetn = 0;
        #1;
        chk("t6_epc", cp0_epc, 32'h0);
        chk("t6_exl", 32'(status_exl), 32'h0);
        chk("t6_taken", 32'(exc_taken), 32'h0);
        chk("t6_target", exc_target, 32'h0);
        rd_at(CP0_STATUS); chk("t6_status", cp0_rdata, 32'h0040_0000);
        rd_at(CP0_COUNT);  chk("t6_count", cp0_rdata, 32'h0);
        rd_at(CP0_CAUSE);  chk("t6_cause", cp0_rdata, 32'h0);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        resetn = 1;
        m_reset();
        repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
